// File: rtl/trail_collision.sv
// trail_collision: once per frame tick, looks at the cell each bike is about to enter.
// A hit is any of: the cell is off the 224x224 arena, the cell is already marked
// in the trail buffer, or both bikes are entering the same cell.
// Hits are ORed into sticky per-bike flags.
// Ports:
//   Clk, Reset          system clock; asynchronous active-low reset
//   frame_clk           frame tick, asynchronous to Clk
//   Game_State          3'b010 = playing; any other value aborts and clears
//   Blue_*/Red_*        bike head cell coordinates and heading
//   rd_addr, re         trail-buffer read request; rd_data returns one Clk later
//   rd_data             trail-buffer word
//   busy                a check is in progress
//   collision_blue/red  sticky collision flags
//   done                one-cycle pulse when a check completes
module trail_collision (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [2:0]  Game_State,
    input  logic [7:0]  Blue_X,
    input  logic [7:0]  Blue_Y,
    input  logic [7:0]  Red_X,
    input  logic [7:0]  Red_Y,
    input  logic [1:0]  Blue_dir,
    input  logic [1:0]  Red_dir,
    output logic [19:0] rd_addr,
    output logic        re,
    input  logic [15:0] rd_data,
    output logic        busy,
    output logic        collision_blue,
    output logic        collision_red,
    output logic        done
);

    localparam int unsigned ADDR_W   = 20;
    localparam int unsigned COORD_W  = 8;
    localparam int unsigned PROBE_W  = 2 * (COORD_W + 1) + 1;
    localparam int unsigned MAX_CELL = 223;
    localparam logic [2:0]  GS_PLAY  = 3'b010;
    localparam logic [1:0]  FILL_MAX = 2'd3;

    typedef enum logic [3:0] {
        IDLE, LATCH, B_RD0, B_RD1, B_EVAL, R_RD0, R_RD1, R_EVAL, REPORT
    } state_e;

    // Probe cell at 9 bits so that 8-bit wrap lands out of range: {wall, px, py}
    function automatic logic [PROBE_W-1:0] probe(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y,
                                                 input logic [1:0]         dir);
        logic [COORD_W:0] px;
        logic [COORD_W:0] py;
        logic             wall;
        px = {1'b0, x};
        py = {1'b0, y};
        case (dir)
            2'b00:   py = py - 9'd1;
            2'b01:   py = py + 9'd1;
            2'b10:   px = px - 9'd1;
            default: px = px + 9'd1;
        endcase
        wall = (px > 9'(MAX_CELL)) || (py > 9'(MAX_CELL));
        return {wall, px, py};
    endfunction

    // Word address 2*PX + 1280*PY, 1280 = 1024 + 256
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] px,
                                                    input logic [COORD_W-1:0] py);
        return (ADDR_W'(px) << 1) + (ADDR_W'(py) << 10) + (ADDR_W'(py) << 8);
    endfunction

    state_e              state_q, state_d;
    logic                sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]          fill_q, fill_d;
    logic [COORD_W-1:0]  bx_q, bx_d, by_q, by_d, rx_q, rx_d, ry_q, ry_d;
    logic [1:0]          bdir_q, bdir_d, rdir_q, rdir_d;
    logic                bhit_q, bhit_d, rhit_q, rhit_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                re_q, re_d, busy_q, busy_d, done_q, done_d;
    logic                coll_b_q, coll_b_d, coll_r_q, coll_r_d;

    logic [PROBE_W-1:0]  blue_live_c, blue_probe_c, red_probe_c;
    logic [ADDR_W-1:0]   blue_addr_c, red_addr_c;
    logic                head_on_c, frame_rise_c, word_occ_c;
    logic                rd_data_unused;

    // Only the two colour nibbles of a trail word mark occupancy
    assign word_occ_c     = (|rd_data[3:0]) || (|rd_data[11:8]);
    assign rd_data_unused = ^{rd_data[15:12], rd_data[7:4]};

    assign blue_live_c  = probe(Blue_X, Blue_Y, Blue_dir);
    assign blue_probe_c = probe(bx_q, by_q, bdir_q);
    assign red_probe_c  = probe(rx_q, ry_q, rdir_q);
    assign blue_addr_c  = cell_addr(blue_probe_c[16:9], blue_probe_c[7:0]);
    assign red_addr_c   = cell_addr(red_probe_c[16:9], red_probe_c[7:0]);
    assign head_on_c    = (blue_probe_c[PROBE_W-2:0] == red_probe_c[PROBE_W-2:0]);

    // Edge detect is held off until the whole synchroniser chain holds real samples,
    // so a frame_clk already high at reset release is not mistaken for an edge
    assign frame_rise_c = (fill_q == FILL_MAX) && sync2_q && !prev_q;

    // State register and all registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            fill_q    <= 2'd0;
            bx_q      <= '0;
            by_q      <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            bdir_q    <= 2'd0;
            rdir_q    <= 2'd0;
            bhit_q    <= 1'b0;
            rhit_q    <= 1'b0;
            rd_addr_q <= '0;
            re_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            coll_b_q  <= 1'b0;
            coll_r_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            fill_q    <= fill_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            bdir_q    <= bdir_d;
            rdir_q    <= rdir_d;
            bhit_q    <= bhit_d;
            rhit_q    <= rhit_d;
            rd_addr_q <= rd_addr_d;
            re_q      <= re_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            coll_b_q  <= coll_b_d;
            coll_r_q  <= coll_r_d;
        end
    end

    // Next state; read requests are registered one state ahead of their slot
    always_comb begin
        state_d   = state_q;
        sync1_d   = frame_clk;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        fill_d    = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 2'd1;
        bx_d      = bx_q;
        by_d      = by_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        bdir_d    = bdir_q;
        rdir_d    = rdir_q;
        bhit_d    = bhit_q;
        rhit_d    = rhit_q;
        rd_addr_d = '0;
        re_d      = 1'b0;
        done_d    = 1'b0;
        coll_b_d  = coll_b_q;
        coll_r_d  = coll_r_q;

        case (state_q)
            IDLE: begin
                if (frame_rise_c) state_d = LATCH;
            end
            LATCH: begin
                state_d   = B_RD0;
                bx_d      = Blue_X;
                by_d      = Blue_Y;
                rx_d      = Red_X;
                ry_d      = Red_Y;
                bdir_d    = Blue_dir;
                rdir_d    = Red_dir;
                bhit_d    = 1'b0;
                rhit_d    = 1'b0;
                rd_addr_d = cell_addr(blue_live_c[16:9], blue_live_c[7:0]);
                re_d      = 1'b1;
            end
            B_RD0: begin
                state_d   = B_RD1;
                rd_addr_d = blue_addr_c + 20'd1;
                re_d      = 1'b1;
            end
            B_RD1: begin
                state_d = B_EVAL;
                bhit_d  = bhit_q || word_occ_c;
            end
            B_EVAL: begin
                state_d   = R_RD0;
                bhit_d    = bhit_q || word_occ_c;
                rd_addr_d = red_addr_c;
                re_d      = 1'b1;
            end
            R_RD0: begin
                state_d   = R_RD1;
                rd_addr_d = red_addr_c + 20'd1;
                re_d      = 1'b1;
            end
            R_RD1: begin
                state_d = R_EVAL;
                rhit_d  = rhit_q || word_occ_c;
            end
            R_EVAL: begin
                state_d = REPORT;
                rhit_d  = rhit_q || word_occ_c;
            end
            REPORT: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                coll_b_d = coll_b_q || bhit_q || blue_probe_c[PROBE_W-1] || head_on_c;
                coll_r_d = coll_r_q || rhit_q || red_probe_c[PROBE_W-1] || head_on_c;
            end
            default: state_d = IDLE;
        endcase

        // Leaving play aborts any check and clears the flags
        if (Game_State != GS_PLAY) begin
            state_d   = IDLE;
            rd_addr_d = '0;
            re_d      = 1'b0;
            done_d    = 1'b0;
            coll_b_d  = 1'b0;
            coll_r_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign rd_addr        = rd_addr_q;
    assign re             = re_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign collision_blue = coll_b_q;
    assign collision_red  = coll_r_q;

endmodule
